// File: rtl/os_types.sv
// Shared types for the memory read arbiter: the forwarded command record and
// the requester-ID width helper.
package os_types;

  localparam int unsigned CMD_ADDR_W = 64;
  localparam int unsigned CMD_LEN_W  = 32;

  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_LEN_W-1:0]  len;
  } mem_rd_cmd_t;

  function automatic int unsigned req_id_width(input int unsigned num_req);
    return (num_req < 2) ? 1 : $clog2(num_req);
  endfunction

endpackage

// File: rtl/id_fifo.sv
// In-order FIFO of requester IDs. Head, full, empty and count all come from
// registers, so a push into an empty FIFO becomes visible one cycle later.
module id_fifo #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one memory channel's read command/data/status path among NUM_REQ
// requesters. Define MEM_READ_ARB_FIXED_PRIO_EN for strict lowest-index priority.
module mem_read_arbiter
  import os_types::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned LEN_WIDTH       = 32,
  parameter int unsigned DATA_WIDTH      = 512,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                                 user_clk,
  input  logic                                 user_aresetn,
  input  logic [NUM_REQ-1:0]                   s_cmd_valid,
  output logic [NUM_REQ-1:0]                   s_cmd_ready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   s_cmd_addr,
  input  logic [NUM_REQ-1:0][LEN_WIDTH-1:0]    s_cmd_len,
  output logic                                 m_cmd_valid,
  input  logic                                 m_cmd_ready,
  output logic [ADDR_WIDTH-1:0]                m_cmd_addr,
  output logic [LEN_WIDTH-1:0]                 m_cmd_len,
  input  logic                                 s_data_valid,
  output logic                                 s_data_ready,
  input  logic                                 s_data_last,
  input  logic [DATA_WIDTH-1:0]                s_data_data,
  input  logic [DATA_WIDTH/8-1:0]              s_data_keep,
  output logic [NUM_REQ-1:0]                   m_data_valid,
  input  logic [NUM_REQ-1:0]                   m_data_ready,
  output logic [NUM_REQ-1:0]                   m_data_last,
  output logic [DATA_WIDTH-1:0]                m_data_data,
  output logic [DATA_WIDTH/8-1:0]              m_data_keep,
  input  logic                                 s_sts_valid,
  output logic                                 s_sts_ready,
  input  logic [7:0]                           s_sts_data,
  output logic [NUM_REQ-1:0]                   m_sts_valid,
  input  logic [NUM_REQ-1:0]                   m_sts_ready,
  output logic [7:0]                           m_sts_data,
  output logic [$clog2(MAX_OUTSTANDING):0]     dbg_data_count,
  output logic [$clog2(MAX_OUTSTANDING):0]     dbg_sts_count
);

  localparam int unsigned ID_W  = req_id_width(NUM_REQ);
  localparam int unsigned IDX_W = ID_W + 1;

  // Valid/ready: a transfer happens on a rising clock edge where both are 1;
  // valid never depends on ready, and ready may depend on valid.

  mem_rd_cmd_t     cmd_q, cmd_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [ID_W-1:0] rr_start, win_id, data_head, sts_head;
  logic [IDX_W-1:0] idx;
  logic            win_found, can_grant, grant;
  logic            data_full, data_empty, sts_full, sts_empty;
  logic            data_pop, sts_pop;

`ifdef MEM_READ_ARB_FIXED_PRIO_EN
  assign rr_start = '0;
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) begin
      rr_ptr_d = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_aresetn) rr_ptr_q <= '0;
    else               rr_ptr_q <= rr_ptr_d;
  end

  assign rr_start = rr_ptr_q;
`endif

  // First valid requester at or after rr_start, wrapping modulo NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, rr_start} + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) idx = idx - IDX_W'(NUM_REQ);
      if (!win_found && s_cmd_valid[idx[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = idx[ID_W-1:0];
      end
    end
  end

  assign can_grant = user_aresetn & (~cmd_valid_q | m_cmd_ready) & ~data_full & ~sts_full;
  assign grant     = can_grant & win_found;

  always_comb begin
    s_cmd_ready = '0;
    if (grant) s_cmd_ready[win_id] = 1'b1;
  end

  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    if (grant) begin
      cmd_valid_d = 1'b1;
      cmd_d.addr  = CMD_ADDR_W'(s_cmd_addr[win_id]);
      cmd_d.len   = CMD_LEN_W'(s_cmd_len[win_id]);
    end else if (m_cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_aresetn) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign m_cmd_valid = cmd_valid_q;
  assign m_cmd_addr  = cmd_q.addr[ADDR_WIDTH-1:0];
  assign m_cmd_len   = cmd_q.len[LEN_WIDTH-1:0];

  // Returned beats and status words go to the oldest outstanding requester.
  always_comb begin
    m_data_valid = '0;
    m_data_last  = '0;
    m_sts_valid  = '0;
    s_data_ready = ~data_empty & m_data_ready[data_head];
    s_sts_ready  = ~sts_empty & m_sts_ready[sts_head];
    if (!data_empty) begin
      m_data_valid[data_head] = s_data_valid;
      m_data_last[data_head]  = s_data_last;
    end
    if (!sts_empty) m_sts_valid[sts_head] = s_sts_valid;
  end

  assign m_data_data = s_data_data;
  assign m_data_keep = s_data_keep;
  assign m_sts_data  = s_sts_data;
  assign data_pop    = s_data_valid & s_data_ready & s_data_last;
  assign sts_pop     = s_sts_valid & s_sts_ready;

  id_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUTSTANDING)) u_data_id_fifo (
    .clk   (user_clk),
    .rst_n (user_aresetn),
    .push  (grant),
    .din   (win_id),
    .pop   (data_pop),
    .head  (data_head),
    .full  (data_full),
    .empty (data_empty),
    .count (dbg_data_count)
  );

  id_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUTSTANDING)) u_sts_id_fifo (
    .clk   (user_clk),
    .rst_n (user_aresetn),
    .push  (grant),
    .din   (win_id),
    .pop   (sts_pop),
    .head  (sts_head),
    .full  (sts_full),
    .empty (sts_empty),
    .count (dbg_sts_count)
  );

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_mem_read_arbiter;

  localparam int N    = 4;
  localparam int AW   = 64;
  localparam int LW   = 32;
  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]          s_cmd_valid, s_cmd_ready;
  logic [N-1:0][AW-1:0]  s_cmd_addr;
  logic [N-1:0][LW-1:0]  s_cmd_len;
  logic                  m_cmd_valid, m_cmd_ready;
  logic [AW-1:0]         m_cmd_addr;
  logic [LW-1:0]         m_cmd_len;
  logic                  s_data_valid, s_data_ready, s_data_last;
  logic [DW-1:0]         s_data_data, m_data_data;
  logic [KW-1:0]         s_data_keep, m_data_keep;
  logic [N-1:0]          m_data_valid, m_data_ready, m_data_last;
  logic                  s_sts_valid, s_sts_ready;
  logic [7:0]            s_sts_data, m_sts_data;
  logic [N-1:0]          m_sts_valid, m_sts_ready;
  logic [3:0]            dbg_data_count, dbg_sts_count;

  mem_read_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .user_clk(clk), .user_aresetn(rst_n),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len),
    .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_last(s_data_last),
    .s_data_data(s_data_data), .s_data_keep(s_data_keep),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_last(m_data_last),
    .m_data_data(m_data_data), .m_data_keep(m_data_keep),
    .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_data(s_sts_data),
    .m_sts_valid(m_sts_valid), .m_sts_ready(m_sts_ready), .m_sts_data(m_sts_data),
    .dbg_data_count(dbg_data_count), .dbg_sts_count(dbg_sts_count)
  );

  int tests = 0;
  int errors = 0;

  // Reference model: outstanding requester IDs in command order, the pending
  // output command, and the round-robin start position.
  logic [2:0]  exp_data_q[$];
  logic [2:0]  exp_sts_q[$];
  int          rr = 0;
  bit          mv = 1'b0;
  logic [63:0] maddr = '0;
  logic [31:0] mlen = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle();
    s_cmd_valid  = '0;
    m_cmd_ready  = 1'b0;
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    s_data_data  = '0;
    s_data_keep  = '0;
    m_data_ready = '1;
    s_sts_valid  = 1'b0;
    s_sts_data   = '0;
    m_sts_ready  = '1;
    for (int j = 0; j < N; j++) begin
      s_cmd_addr[j] = 64'h100 * (j + 1);
      s_cmd_len[j]  = 32'd64;
    end
  endtask

  // One clock: check all outputs against the model mid-cycle, then advance
  // the model with the handshakes that complete at the rising edge.
  task automatic step();
    bit         can, sdr, ssr;
    int         win, dh, sh;
    logic [N-1:0] exp_rdy, exp_mdv, exp_mdl, exp_msv;
    #1;
    for (int j = 0; j < N; j++)
      if (s_cmd_valid[j]) assert (s_cmd_len[j] != 0) else $error("zero-length command from req %0d", j);
    can = rst_n && (!mv || m_cmd_ready) && exp_data_q.size() < MAXO && exp_sts_q.size() < MAXO;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (rr + k) % N;
      if (win < 0 && s_cmd_valid[j]) win = j;
    end
    exp_rdy = (can && win >= 0) ? N'(1 << win) : '0;
    dh = (exp_data_q.size() > 0) ? int'(exp_data_q[0]) : -1;
    sh = (exp_sts_q.size() > 0) ? int'(exp_sts_q[0]) : -1;
    sdr = (dh >= 0) && m_data_ready[dh];
    ssr = (sh >= 0) && m_sts_ready[sh];
    exp_mdv = (dh >= 0 && s_data_valid) ? N'(1 << dh) : '0;
    exp_mdl = (dh >= 0 && s_data_last)  ? N'(1 << dh) : '0;
    exp_msv = (sh >= 0 && s_sts_valid)  ? N'(1 << sh) : '0;
    check_eq("s_cmd_ready", s_cmd_ready, exp_rdy);
    check_eq("m_cmd_valid", m_cmd_valid, mv);
    check_eq("m_cmd_addr", m_cmd_addr, maddr);
    check_eq("m_cmd_len", m_cmd_len, mlen);
    check_eq("m_data_valid", m_data_valid, exp_mdv);
    check_eq("m_data_last", m_data_last, exp_mdl);
    check_eq("s_data_ready", s_data_ready, sdr);
    check_eq("m_sts_valid", m_sts_valid, exp_msv);
    check_eq("s_sts_ready", s_sts_ready, ssr);
    check_eq("m_data_data", m_data_data[63:0], s_data_data[63:0]);
    check_eq("m_sts_data", m_sts_data, s_sts_data);
    check_eq("data_count", dbg_data_count, exp_data_q.size());
    check_eq("sts_count", dbg_sts_count, exp_sts_q.size());
    @(posedge clk);
    if (!rst_n) begin
      exp_data_q.delete();
      exp_sts_q.delete();
      mv = 1'b0; maddr = '0; mlen = '0; rr = 0;
    end else begin
      if (s_data_valid && sdr && s_data_last) void'(exp_data_q.pop_front());
      if (s_sts_valid && ssr) void'(exp_sts_q.pop_front());
      if (exp_rdy != '0) begin
        mv = 1'b1;
        maddr = s_cmd_addr[win];
        mlen = s_cmd_len[win];
        exp_data_q.push_back(3'(win));
        exp_sts_q.push_back(3'(win));
`ifndef MEM_READ_ARB_FIXED_PRIO_EN
        rr = (win + 1) % N;
`endif
      end else if (m_cmd_ready) begin
        mv = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic return_all();
    s_data_valid = 1'b1; s_data_last = 1'b1; m_data_ready = '1;
    s_sts_valid = 1'b1; m_sts_ready = '1;
  endtask

  initial begin
    logic [N-1:0] exp_ord;
    idle();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_m_cmd_valid", m_cmd_valid, 0);
    check_eq("rst_s_cmd_ready", s_cmd_ready, 0);
    check_eq("rst_m_cmd_addr", m_cmd_addr, 0);
    step();

    // Single command from req2, two beats, one status word.
    s_cmd_valid = 4'b0100; s_cmd_addr[2] = 64'h1000; s_cmd_len[2] = 32'd128;
    step();
    s_cmd_valid = '0;
    check_eq("single_cmd_valid", m_cmd_valid, 1);
    check_eq("single_cmd_addr", m_cmd_addr, 64'h1000);
    check_eq("single_cmd_len", m_cmd_len, 128);
    m_cmd_ready = 1'b1;
    s_data_valid = 1'b1; s_data_last = 1'b0; s_data_data = DW'(64'hdead_beef_0001);
    #1 check_eq("single_beat1", m_data_valid, 4'b0100);
    step();
    s_data_last = 1'b1; s_data_data = DW'(64'hdead_beef_0002);
    #1 check_eq("single_beat2_last", m_data_last, 4'b0100);
    step();
    s_data_valid = 1'b0; s_data_last = 1'b0;
    s_sts_valid = 1'b1; s_sts_data = 8'h5a;
    #1 check_eq("single_sts", m_sts_valid, 4'b0100);
    step();
    s_sts_valid = 1'b0;
    step();

    // All requesters valid, memory drains everything each cycle.
    do_reset();
    s_cmd_valid = '1; m_cmd_ready = 1'b1; return_all();
    for (int i = 0; i < 12; i++) begin
`ifdef MEM_READ_ARB_FIXED_PRIO_EN
      exp_ord = 4'b0001;
`else
      exp_ord = N'(1 << (i % N));
`endif
      #1 check_eq("rr_order", s_cmd_ready, exp_ord);
      step();
    end

    // Outstanding limit: eight grants, then blocked until a completion.
    do_reset();
    s_cmd_valid = 4'b0001; m_cmd_ready = 1'b1;
    for (int i = 0; i < MAXO; i++) begin
      #1 check_eq("outst_grant", s_cmd_ready, 4'b0001);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("outst_blocked", s_cmd_ready, 0);
      step();
    end
    return_all();
    #1 check_eq("outst_same_cycle", s_cmd_ready, 0);
    step();
    s_data_valid = 1'b0; s_sts_valid = 1'b0;
    #1 check_eq("outst_regrant", s_cmd_ready, 4'b0001);
    step();

    // Command and data backpressure.
    do_reset();
    s_cmd_valid = 4'b0011; s_cmd_addr[0] = 64'hA0; s_cmd_addr[1] = 64'hB0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1 check_eq("bp_no_grant", s_cmd_ready, 0);
      check_eq("bp_cmd_hold", m_cmd_addr, 64'hA0);
      step();
    end
    s_cmd_valid = '0; s_data_valid = 1'b1; m_data_ready = '0;
    #1 check_eq("bp_data_ready", s_data_ready, 0);
    step();
    m_cmd_ready = 1'b1; s_data_valid = 1'b0; m_data_ready = '1;
    step();

    // Ordering: req1 (3 beats) then req3 (1 beat) back to back.
    do_reset();
    m_cmd_ready = 1'b1;
    s_cmd_valid = 4'b0010; s_cmd_len[1] = 32'd192;
    step();
    s_cmd_valid = 4'b1000; s_cmd_len[3] = 32'd64;
    step();
    s_cmd_valid = '0; s_data_valid = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_data_last = (b >= 2);
      #1 check_eq("order_beat", m_data_valid, (b < 3) ? 4'b0010 : 4'b1000);
      step();
    end
    s_data_valid = 1'b0; s_data_last = 1'b0; s_sts_valid = 1'b1;
    #1 check_eq("order_sts0", m_sts_valid, 4'b0010);
    step();
    #1 check_eq("order_sts1", m_sts_valid, 4'b1000);
    step();
    s_sts_valid = 1'b0;

    // Requesters 0 and 3 contending.
    do_reset();
    s_cmd_valid = 4'b1001; m_cmd_ready = 1'b1; return_all();
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_READ_ARB_FIXED_PRIO_EN
      exp_ord = 4'b0001;
`else
      exp_ord = (i % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      #1 check_eq("prio_pair", s_cmd_ready, exp_ord);
      step();
    end

    // Reset after three grants clears everything.
    do_reset();
    s_cmd_valid = 4'b0111; m_cmd_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    s_data_valid = 1'b1;
    check_eq("midrst_cmd_valid", m_cmd_valid, 0);
    check_eq("midrst_cmd_addr", m_cmd_addr, 0);
    check_eq("midrst_data_cnt", dbg_data_count, 0);
    check_eq("midrst_sts_cnt", dbg_sts_count, 0);
    check_eq("midrst_data_ready", s_data_ready, 0);
    step();

    // Random traffic, occasional reset.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      s_cmd_valid  = N'($urandom);
      for (int j = 0; j < N; j++) begin
        s_cmd_addr[j] = {$urandom, $urandom};
        s_cmd_len[j]  = $urandom_range(1, 4096);
      end
      m_cmd_ready  = ($urandom_range(0, 3) != 0);
      s_data_valid = $urandom_range(0, 1);
      s_data_last  = ($urandom_range(0, 2) == 0);
      s_data_data  = DW'({$urandom, $urandom});
      s_data_keep  = KW'({$urandom, $urandom});
      m_data_ready = N'($urandom) | N'($urandom);
      s_sts_valid  = ($urandom_range(0, 2) == 0);
      s_sts_data   = 8'($urandom);
      m_sts_ready  = N'($urandom) | N'($urandom);
      step();
    end
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
